column_frame_strobe_gen: RTL and testbench

Per-column configuration frame loader that sits directly upstream of the bottom terminal tile of a fabric column. It accepts a 32-bit configuration word stream with a valid/ready handshake and assembles one column frame of `FrameBitsPerRow*NumberOfRows` bits. It then drives the column's `FrameData` bus and fires the one-hot `FrameStrobe` bit for the addressed frame. The strobe is buffered up the column through each tile's `FrameStrobe` inputs.

---
 rtl/column_frame_strobe_gen_if.sv | 10 +
 rtl/column_frame_strobe_gen.sv | 110 +++++++++++
 tb/tb_column_frame_strobe_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/column_frame_strobe_gen_if.sv
// Configuration word stream into a column frame loader: 32-bit word with valid/ready.
// master drives words, slave (the loader) returns ready.
interface column_frame_strobe_gen_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/column_frame_strobe_gen.sv
// Column frame loader: header + NumberOfRows data words -> FrameData, one-hot FrameStrobe pulse.
// Latency: strobe fires at the edge accepting the last data word, for one cycle.
// Backpressure: in_ready = MODE except during the strobe cycle; FSG_HEADER_PARITY_EN adds odd header parity.
module column_frame_strobe_gen #(
    parameter int         MaxFramesPerCol = 20,
    parameter int         FrameBitsPerRow = 32,
    parameter int         NumberOfRows    = 16,
    parameter logic [7:0] COL_ID          = 8'd0
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      MODE,
    column_frame_strobe_gen_if.slave                  cfg,
    output logic [FrameBitsPerRow*NumberOfRows-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]                FrameStrobe,
    output logic                                      busy,
    output logic                                      err
);

    localparam int CW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SKIP   = 2'd2;
    localparam logic [1:0] S_STROBE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [4:0]    idx_q;
    logic          accept;
    logic          last_row;
    logic          hdr_col_ok;
    logic          hdr_idx_ok;
    logic          hdr_par_ok;

    assign cfg.in_ready = !RST && MODE && (state != S_STROBE);
    assign accept       = cfg.in_valid && cfg.in_ready;
    assign last_row     = (cnt == CW'(NumberOfRows - 1));
    assign hdr_col_ok   = (cfg.in_data[15:8] == COL_ID);
    assign hdr_idx_ok   = ($unsigned(32'(cfg.in_data[4:0])) < $unsigned(32'(MaxFramesPerCol)));
    assign busy         = (state != S_IDLE);

`ifdef FSG_HEADER_PARITY_EN
    // Whole header word, bit 31 included, must XOR to 1.
    assign hdr_par_ok = ^cfg.in_data;
`else
    assign hdr_par_ok = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx_q       <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            err         <= 1'b0;
        end else begin
            FrameStrobe <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        // A parity failure is flagged even for frames aimed at other columns.
                        if (!hdr_par_ok) begin
                            err   <= 1'b1;
                            state <= S_SKIP;
                        end else if (!hdr_col_ok) begin
                            state <= S_SKIP;
                        end else if (!hdr_idx_ok) begin
                            err   <= 1'b1;
                            state <= S_SKIP;
                        end else begin
                            idx_q <= cfg.in_data[4:0];
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (!MODE) begin
                        state <= S_IDLE;
                    end else if (accept) begin
                        for (int r = 0; r < NumberOfRows; r++) begin
                            if (cnt == CW'(r))
                                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= cfg.in_data;
                        end
                        cnt <= cnt + 1'b1;
                        if (last_row) begin
                            state <= S_STROBE;
                            for (int f = 0; f < MaxFramesPerCol; f++)
                                FrameStrobe[f] <= (idx_q == 5'(f));
                        end
                    end
                end
                S_SKIP: begin
                    if (!MODE) begin
                        state <= S_IDLE;
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (last_row)
                            state <= S_IDLE;
                    end
                end
                S_STROBE: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_frame_strobe_gen.sv
// Scoreboard bench: the driver queues each expected strobe with its frame image and cycle,
// and a negedge monitor checks every strobe, its width and the in_ready pattern.
module tb_column_frame_strobe_gen;

    logic         CLK = 1'b0;
    logic         RST;
    logic         MODE;
    logic [511:0] FrameData;
    logic [19:0]  FrameStrobe;
    logic         busy;
    logic         err;

    column_frame_strobe_gen_if cfg_if ();

    column_frame_strobe_gen #(
        .MaxFramesPerCol(20), .FrameBitsPerRow(32), .NumberOfRows(16), .COL_ID(8'd3)
    ) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .cfg(cfg_if),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [19:0]  stb;
        logic [511:0] dat;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    logic [511:0] model_fd = '0;
    int           cyc = 0;
    int           strobe_cyc = -1;
    int           checks = 0;
    int           errors = 0;
    bit           prev_stb = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] make_hdr(input logic [7:0] col, input logic [4:0] idx);
        logic [31:0] h;
        h     = {16'h0, col, 3'b000, idx};
        h[31] = ~(^h[30:0]);
        return h;
    endfunction

    task automatic send_word(input logic [31:0] d, output bit ok);
        cfg_if.in_data  = d;
        cfg_if.in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge CLK);
            if (cfg_if.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) @(posedge CLK);
        #1;
        cfg_if.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %0h not accepted within 100 cycles", d);
        end
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base, input bit load,
                              input logic [19:0] stb, input bit stall, input int n);
        bit ok;
        send_word(hdr, ok);
        for (int k = 0; k < n; k++) begin
            if (stall) @(posedge CLK) #1;
            send_word(base + 32'(k), ok);
            if (load && ok) model_fd[k*32 +: 32] = base + 32'(k);
        end
        if (stb != 20'h0) begin
            sb_q.push_back('{stb: stb, dat: model_fd, cyc: cyc});
            strobe_cyc = cyc;
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard and last one cycle.
    always @(negedge CLK) begin
        exp_t e;
        chk("in_ready", 512'(cfg_if.in_ready), 512'(MODE && !RST && (cyc != strobe_cyc)));
        if (FrameStrobe != 20'h0) begin
            if (prev_stb) chk("strobe_width", 512'(FrameStrobe), 512'(0));
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", 512'(FrameStrobe), 512'(0));
            end else begin
                e = sb_q.pop_front();
                chk("strobe_val", 512'(FrameStrobe), 512'(e.stb));
                chk("strobe_data", FrameData, e.dat);
                chk("strobe_cycle", 512'(cyc), 512'(e.cyc));
            end
        end
        prev_stb = (FrameStrobe != 20'h0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        MODE = 1'b1;
        cfg_if.in_data  = '0;
        cfg_if.in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", 512'(cfg_if.in_ready), 512'(0));
        chk("rst_strobe", 512'(FrameStrobe), 512'(0));
        chk("rst_data", FrameData, 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_err", 512'(err), 512'(0));
        RST = 1'b0;
        @(posedge CLK) #1;

        // Nominal frame, index 5
        send_frame(make_hdr(8'd3, 5'd5), 32'hA5A5_0000, 1'b1, 20'h00020, 1'b0, 16);
        @(posedge CLK) #1;
        chk("nom_err", 512'(err), 512'(0));
        chk("nom_data", FrameData, model_fd);

        // Column mismatch
        send_frame(make_hdr(8'd7, 5'd5), 32'h1111_0000, 1'b0, 20'h0, 1'b0, 16);
        chk("mis_busy", 512'(busy), 512'(0));
        chk("mis_err", 512'(err), 512'(0));
        chk("mis_data", FrameData, model_fd);

        // Bad index, then a good frame still strobes
        send_frame(make_hdr(8'd3, 5'd20), 32'h2222_0000, 1'b0, 20'h0, 1'b0, 16);
        chk("bad_err", 512'(err), 512'(1));
        chk("bad_data", FrameData, model_fd);
        send_frame(make_hdr(8'd3, 5'd7), 32'h2222_0000, 1'b1, 20'h00080, 1'b0, 16);
        @(posedge CLK) #1;
        chk("bad_err_sticky", 512'(err), 512'(1));

        // MODE abort after 8 data words
        send_frame(make_hdr(8'd3, 5'd2), 32'h3333_0000, 1'b1, 20'h0, 1'b0, 8);
        MODE = 1'b0;
        #1;
        chk("abort_ready", 512'(cfg_if.in_ready), 512'(0));
        chk("abort_busy_before", 512'(busy), 512'(1));
        @(posedge CLK) #1;
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_data", FrameData, model_fd);
        MODE = 1'b1;
        @(posedge CLK) #1;

        // Back-to-back with in_valid toggling
        send_frame(make_hdr(8'd3, 5'd0),  32'h4444_0000, 1'b1, 20'h00001, 1'b1, 16);
        send_frame(make_hdr(8'd3, 5'd19), 32'h5555_0000, 1'b1, 20'h80000, 1'b1, 16);
        @(posedge CLK) #1;
        chk("b2b_data", FrameData, model_fd);

        // Reset mid-LOAD
        send_frame(make_hdr(8'd3, 5'd9), 32'h6666_0000, 1'b1, 20'h0, 1'b0, 5);
        RST = 1'b1;
        @(posedge CLK) #1;
        model_fd = '0;
        chk("mid_rst_data", FrameData, 512'(0));
        chk("mid_rst_busy", 512'(busy), 512'(0));
        chk("mid_rst_err", 512'(err), 512'(0));
        chk("mid_rst_strobe", 512'(FrameStrobe), 512'(0));
        RST = 1'b0;
        @(posedge CLK) #1;

`ifdef FSG_HEADER_PARITY_EN
        send_frame(32'h0000_0305, 32'h6666_0000, 1'b0, 20'h0, 1'b0, 16);
        chk("par_err", 512'(err), 512'(1));
`endif
        send_frame(32'h8000_0305, 32'h7777_0000, 1'b1, 20'h00020, 1'b0, 16);
        repeat (4) @(posedge CLK);
        #1;
        chk("final_data", FrameData, model_fd);
        chk("sb_empty", 512'(sb_q.size()), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
